// File: rtl/weighted_sum_pkg.sv
// Shared types and width helpers for the time-multiplexed weighted-sum engine.
package weighted_sum_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int DEF_ACCW = 48;

  function automatic int prod_w(input int dw);
    return 2 * dw;
  endfunction

  function automatic int tree_w(input int dw, input int m);
    return 2 * dw + $clog2(m);
  endfunction

endpackage

// File: rtl/weighted_sum_tree.sv
// Stages 1-2 of the weighted-sum pipeline: M signed lane products, then their
// registered sum. Valid and first-beat tags travel alongside the data.
module weighted_sum_tree
  import weighted_sum_pkg::*;
#(
  parameter int M  = 8,
  parameter int DW = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_vld,
  input  logic                              in_first,
  input  logic [DW*M-1:0]                   in_x,
  input  logic [DW*M-1:0]                   in_w,
  output logic                              vld_p0,
  output logic                              vld_p1,
  output logic                              first_p1,
  output logic signed [tree_w(DW, M)-1:0]   sum_p1
);

  localparam int PW = prod_w(DW);
  localparam int TW = tree_w(DW, M);

  logic signed [PW-1:0] prod_p0 [M];
  logic                 first_p0;
  logic signed [TW-1:0] tree_sum;

  // Stage 1: lane products
  always_ff @(posedge clk) begin
    if (in_vld) begin
      for (int k = 0; k < M; k++) begin
        prod_p0[k] <= PW'($signed(in_x[DW*k +: DW])) * PW'($signed(in_w[DW*k +: DW]));
      end
    end
  end

  // Written as a chain; synthesis rebalances it into a tree.
  always_comb begin
    tree_sum = '0;
    for (int k = 0; k < M; k++) begin
      tree_sum = tree_sum + TW'(prod_p0[k]);
    end
  end

  // Stage 2: lane sum
  always_ff @(posedge clk) begin
    if (vld_p0) begin
      sum_p1 <= tree_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0   <= 1'b0;
      first_p0 <= 1'b0;
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
    end else begin
      vld_p0   <= in_vld;
      first_p0 <= in_first;
      vld_p1   <= vld_p0;
      first_p1 <= first_p0;
    end
  end

endmodule

// File: rtl/weighted_sum_tdm.sv
// Time-multiplexed weighted sum over N inputs using M multiplier lanes.
// Optional step activation output is enabled by WEIGHTED_SUM_TDM_STEP_ACT_EN.
module weighted_sum_tdm
  import weighted_sum_pkg::*;
#(
  parameter int N    = 32,
  parameter int M    = 8,
  parameter int DW   = 16,
  parameter int ACCW = DEF_ACCW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DW*M-1:0]        in_x,
  input  logic [DW*M-1:0]        in_w,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [ACCW-1:0] out_sum
`ifdef WEIGHTED_SUM_TDM_STEP_ACT_EN
  ,
  input  logic signed [ACCW-1:0] threshold,
  output logic                   out_fire
`endif
);

  localparam int B  = N / M;
  localparam int CW = (B > 1) ? $clog2(B) : 1;
  localparam int TW = tree_w(DW, M);

  if (N % M != 0) begin : g_chk_n
    $error("weighted_sum_tdm: N must be a multiple of M");
  end
  if (M < 1 || M > 16 || (M & (M - 1)) != 0) begin : g_chk_m
    $error("weighted_sum_tdm: M must be a power of two in 1..16");
  end
  if (ACCW < 2 * DW + $clog2(N)) begin : g_chk_accw
    $error("weighted_sum_tdm: ACCW too narrow for N products");
  end

  state_e               state;
  logic [CW-1:0]        beat_cnt;
  logic                 accept;
  logic                 beat_last;
  logic                 vld_p0;
  logic                 vld_p1;
  logic                 first_p1;
  logic signed [TW-1:0] sum_p1;
  logic signed [ACCW-1:0] sum_ext;
  logic signed [ACCW-1:0] acc_p2;
  logic                 drain_done;
`ifdef WEIGHTED_SUM_TDM_STEP_ACT_EN
  logic signed [ACCW-1:0] thr_r;
`endif

  assign accept     = in_valid && in_ready;
  assign beat_last  = (beat_cnt == CW'(B - 1));
  assign sum_ext    = ACCW'(sum_p1);
  // Nothing left in stages 1-2 means the accumulator already holds the final sum.
  assign drain_done = !vld_p0 && !vld_p1;

  weighted_sum_tree #(
    .M  (M),
    .DW (DW)
  ) u_tree (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (accept),
    .in_first (accept && (beat_cnt == '0)),
    .in_x     (in_x),
    .in_w     (in_w),
    .vld_p0   (vld_p0),
    .vld_p1   (vld_p1),
    .first_p1 (first_p1),
    .sum_p1   (sum_p1)
  );

  // Stage 3: accumulate, beat 0 reloads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p2 <= '0;
    end else if (vld_p1) begin
      acc_p2 <= first_p1 ? sum_ext : acc_p2 + sum_ext;
    end
  end

`ifdef WEIGHTED_SUM_TDM_STEP_ACT_EN
  always_ff @(posedge clk) begin
    if (accept && beat_last) begin
      thr_r <= threshold;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      beat_cnt  <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
`ifdef WEIGHTED_SUM_TDM_STEP_ACT_EN
      out_fire  <= 1'b0;
`endif
    end else begin
      case (state)
        LOAD: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (beat_last) begin
              beat_cnt <= '0;
              in_ready <= 1'b0;
              state    <= DRAIN;
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
            end
          end
        end
        DRAIN: begin
          if (drain_done) begin
            out_sum   <= acc_p2;
            out_valid <= 1'b1;
`ifdef WEIGHTED_SUM_TDM_STEP_ACT_EN
            out_fire  <= (acc_p2 >= thr_r);
`endif
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= LOAD;
          end
        end
        default: begin
          state    <= LOAD;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weighted_sum_tdm.sv
// Randomized and directed bench for weighted_sum_tdm against a plain dot-product model.
module tb_weighted_sum_tdm;

  localparam int N    = 32;
  localparam int M    = 8;
  localparam int DW   = 16;
  localparam int ACCW = 48;
  localparam int B    = N / M;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [DW*M-1:0]        in_x = '0;
  logic [DW*M-1:0]        in_w = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic signed [ACCW-1:0] out_sum;
`ifdef WEIGHTED_SUM_TDM_STEP_ACT_EN
  logic signed [ACCW-1:0] threshold = '0;
  logic                   out_fire;
`endif

  int checks = 0;
  int errors = 0;
  int x_v [N];
  int w_v [N];

  always #5 clk = ~clk;

  weighted_sum_tdm #(
    .N    (N),
    .M    (M),
    .DW   (DW),
    .ACCW (ACCW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_w      (in_w),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum)
`ifdef WEIGHTED_SUM_TDM_STEP_ACT_EN
    ,
    .threshold (threshold),
    .out_fire  (out_fire)
`endif
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint ref_sum();
    longint s = 0;
    for (int i = 0; i < N; i++) s += longint'(x_v[i]) * longint'(w_v[i]);
    return s;
  endfunction

  task automatic fill(input int xv, input int wv);
    for (int i = 0; i < N; i++) begin
      x_v[i] = xv;
      w_v[i] = wv;
    end
  endtask

  // gap_mode: 0 back-to-back, 1 one idle cycle between beats, 2 random idle cycles
  task automatic send_vec(input int nbeats, input int gap_mode);
    for (int j = 0; j < nbeats; j++) begin
      int n = 0;
      for (int k = 0; k < M; k++) begin
        in_x[DW*k +: DW] = x_v[j*M+k][DW-1:0];
        in_w[DW*k +: DW] = w_v[j*M+k][DW-1:0];
      end
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 100) chk("in_ready_timeout", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (j < nbeats - 1) begin
        if (gap_mode == 1) begin
          @(posedge clk); #1;
        end else if (gap_mode == 2) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
        end
      end
    end
  endtask

  // Called 1ns after the last-beat edge: checks latency, sum and stability under backpressure.
  task automatic get_result(input string tag, input logic signed [63:0] exp, input int hold);
    int n = 0;
    logic signed [ACCW-1:0] s0;
    logic bad = 1'b0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, n, 3);
    chk({tag, "_sum"}, out_sum, exp);
    s0 = out_sum;
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_sum !== s0 || in_ready !== 1'b0) bad = 1'b1;
    end
    if (hold > 0) chk({tag, "_hold_stable"}, bad, 0);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_valid_after_hs"}, out_valid, 0);
    chk({tag, "_ready_after_hs"}, in_ready, 1);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #10;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    #10 rst_n = 1'b1;
    #1;
    chk("release_in_ready_low", in_ready, 0);
    @(posedge clk); #1;
    chk("release_in_ready_high", in_ready, 1);

    // all ones, threshold at the sum
    fill(1, 1);
`ifdef WEIGHTED_SUM_TDM_STEP_ACT_EN
    threshold = 48'sd32;
`endif
    send_vec(B, 0);
    get_result("ones", 64'sd32, 0);
`ifdef WEIGHTED_SUM_TDM_STEP_ACT_EN
    chk("fire_thr32", out_fire, 1);
`endif
    handshake("ones");

    // same vector, threshold one above, out_ready held high beforehand
`ifdef WEIGHTED_SUM_TDM_STEP_ACT_EN
    threshold = 48'sd33;
`endif
    out_ready = 1'b1;
    send_vec(B, 0);
    out_ready = 1'b0;
    get_result("ones_rdy", 64'sd32, 0);
`ifdef WEIGHTED_SUM_TDM_STEP_ACT_EN
    chk("fire_thr33", out_fire, 0);
`endif
    handshake("ones_rdy");

    fill(-32768, -32768);
    send_vec(B, 0);
    get_result("minmin", 64'sd34359738368, 0);
    handshake("minmin");

    fill(-32768, 32767);
    send_vec(B, 0);
    get_result("minmax", -64'sd34358689792, 0);
    handshake("minmax");

    for (int i = 0; i < N; i++) begin
      x_v[i] = i;
      w_v[i] = 1;
    end
    send_vec(B, 1);
    get_result("ramp_gaps", 64'sd496, 0);
    handshake("ramp_gaps");
    send_vec(B, 0);
    get_result("ramp_bp", 64'sd496, 10);
    handshake("ramp_bp");
    send_vec(B, 0);
    get_result("ramp_next", 64'sd496, 0);
    handshake("ramp_next");

    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < N; i++) begin
        x_v[i] = int'($urandom_range(0, 65535)) - 32768;
        w_v[i] = int'($urandom_range(0, 65535)) - 32768;
      end
      send_vec(B, 2);
      get_result("rand", ref_sum(), int'($urandom_range(0, 4)));
      handshake("rand");
    end

    // reset while a result is held
    fill(5, -7);
    send_vec(B, 0);
    get_result("pre_rst", ref_sum(), 0);
    rst_n = 1'b0;
    #1;
    chk("rst_hold_valid", out_valid, 0);
    chk("rst_hold_sum", out_sum, 0);
    chk("rst_hold_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // reset after beat 1, then a clean vector
    fill(100, 100);
    send_vec(2, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_sum", out_sum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    fill(2, 3);
    send_vec(B, 0);
    get_result("after_rst", 64'sd192, 0);
    handshake("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/weighted_sum_tdm.md
# weighted_sum_tdm

Time-multiplexed, parametrised weighted-sum engine for the perceptron datapath. It computes sum(x[i]*w[i]) over N signed inputs using only M multiplier lanes, so N may exceed the DSP slice budget. Inputs arrive as N/M beats over a valid/ready stream, and one accumulated result is returned per vector on an output valid/ready handshake. It replaces the fixed-N cascaded-slice sum wherever N > slice count or backpressure is needed.

## Interface
- N, 32: inputs per vector; N % M == 0 is required, checked at elaboration.
- M, 8: parallel multiplier lanes per beat; power of two, 1..16.
- DW, 16: signed width of each x and w element.
- ACCW, 48: accumulator/result width; ACCW >= 2*DW + $clog2(N) is required, checked at elaboration.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_x  in  DW*M  lane k at bits [DW*(k+1)-1 : DW*k], signed.
- in_w  in  DW*M  weights, same packing as in_x.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_sum  out  ACCW  signed weighted sum of the vector.

## Operation
- B = N/M beats form one vector; beat j carries elements j*M .. j*M+M-1.
- Pipeline per accepted beat:
  - stage 1 registers M signed 2*DW products;
  - stage 2 registers the adder-tree sum (2*DW + $clog2(M) bits);
  - stage 3 adds the sign-extended tree sum into the accumulator.
- Each beat carries a first tag: the stage-3 add of beat 0 loads the accumulator instead of adding to it.
- Overflow is impossible under the ACCW rule, so there is no saturation.
- FSM states:
  - LOAD: in_ready=1; beat counter increments per accepted beat; accepting beat B-1 -> DRAIN.
  - DRAIN: in_ready=0; waits until the last beat leaves stage 3, then out_sum is registered -> HOLD.
  - HOLD: out_valid=1; out_sum and out_valid stay stable until the handshake; on handshake -> LOAD.
- in_valid may drop between beats. Bubbles carry a valid=0 tag and leave the accumulator unchanged.
- The beat counter wraps to 0 after B-1.
- A beat must not be accepted in DRAIN or HOLD; in_ready guarantees this.

## Timing
- Reset (rst_n low, asynchronous) clears:
  - state to LOAD;
  - beat counter, all pipeline valid tags and the accumulator to 0;
  - out_valid=0, out_sum=0.
- in_ready=0 while rst_n is low and is 1 from the first clock after release.
- Reset mid-vector discards partial sums; the next accepted beat is beat 0.
- Latency: last beat accepted at edge t -> out_valid=1 after edge t+3.
- Handshake at edge h -> out_valid=0 and in_ready=1 after h; a new beat 0 is accepted at h+1 at the earliest.
- Minimum vector period: B + 4 cycles.
- out_ready=1 when out_valid=0 has no effect.

## Configuration
- WEIGHTED_SUM_TDM_STEP_ACT_EN defined:
  - adds input `threshold` [ACCW] (signed), sampled when beat B-1 is accepted;
  - adds output `out_fire` (1 bit) = ($signed(sum) >= threshold), registered with out_sum, reset 0, held in HOLD.
- Undefined: both ports are absent and no comparator is built.

## Structure
- Package weighted_sum_pkg holds:
  - the FSM state enum (LOAD, DRAIN, HOLD);
  - the default ACCW;
  - the width functions: product width 2*DW, tree width 2*DW + $clog2(M).
- Sub-module weighted_sum_tree covers stages 1 and 2: M signed multipliers plus a registered adder tree, with a valid/first tag passed alongside the data. The top level holds the FSM, counter, accumulator and output register.

## Test plan
Defaults for all scenarios: N=32, M=8, DW=16.
- All x=1, w=1, 4 consecutive beats -> out_sum=32, out_valid rises 3 cycles after the last beat edge.
- All x=-32768, w=-32768 -> out_sum=34359738368; all x=-32768, w=32767 -> out_sum=-34358689792.
- x[i]=i, w[i]=1, in_valid toggled 1/0 between beats -> out_sum=496, identical to the gap-free run.
- out_ready held low 10 cycles -> out_valid=1, out_sum stable, in_ready=0 throughout; the next vector is accepted the cycle after the handshake.
- rst_n pulsed low after beat 1 -> out_valid=0, out_sum=0 immediately; the following full vector of x=2, w=3 -> out_sum=192.
- With the macro defined and the 32-result vector: threshold=32 -> out_fire=1; threshold=33 -> out_fire=0.
